// File: rtl/led_frame_sched_if.sv
// rtl/led_frame_sched_if.sv - FIFO write port and sender handshake bundle
interface led_frame_sched_if;
    logic        we;
    logic [11:0] fifo_data_in;
    logic        fifo_full;
    logic        send_start;
    logic        send_done;

    modport master (
        output we, fifo_data_in, send_start,
        input  fifo_full, send_done
    );

    modport slave (
        input  we, fifo_data_in, send_start,
        output fifo_full, send_done
    );
endinterface

// File: rtl/led_frame_sched.sv
// rtl/led_frame_sched.sv - LED frame scheduler: snapshot, FIFO load, kick, await done
module led_frame_sched #(
    parameter int NCH            = 8,
    parameter int REFRESH_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk_slow,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     start,
    input  logic [3:0]               MeanR [NCH],
    input  logic [3:0]               MeanG [NCH],
    input  logic [3:0]               MeanB [NCH],
    led_frame_sched_if.master        sif,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic                     err_timeout
);
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_KICK  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [11:0]   shadow_q [NCH];
    logic [11:0]   shadow_d [NCH];
    logic [11:0]   data_q, data_d;
    logic [15:0]   frame_q, frame_d;
    logic          err_q, err_d;
    logic          tick, trig, we_c;

    always_comb begin
        tick      = en && (refresh_q == REF_LAST);
        trig      = start || tick;
        refresh_d = (!en || tick) ? '0 : refresh_q + 1'b1;
        we_c      = (state_q == S_WRITE) && !sif.fifo_full;
        state_d   = state_q;
        pending_d = pending_q;
        ch_d      = ch_q;
        tmo_d     = tmo_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        frame_d   = frame_q;
        err_d     = err_q;

        // Requests arriving mid-frame collapse into a single queued frame.
        if (state_q != S_IDLE && trig)
            pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (trig || pending_q) begin
                    state_d   = S_LATCH;
                    pending_d = 1'b0;
                    if (start)
                        err_d = 1'b0;
                end
            end
            S_LATCH: begin
                for (int i = 0; i < NCH; i++)
                    shadow_d[i] = {MeanR[i], MeanG[i], MeanB[i]};
                data_d  = {MeanR[0], MeanG[0], MeanB[0]};
                ch_d    = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // data_q already holds the word for ch_q; advance only on an accepted write.
                if (we_c) begin
                    if (ch_q == CH_LAST) begin
                        state_d = S_KICK;
                    end else begin
                        ch_d   = ch_q + 1'b1;
                        data_d = shadow_q[ch_q + 1'b1];
                    end
                end
            end
            S_KICK: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sif.send_done) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                frame_d = frame_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_slow) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            refresh_q <= '0;
            pending_q <= 1'b0;
            ch_q      <= '0;
            tmo_q     <= '0;
            for (int i = 0; i < NCH; i++)
                shadow_q[i] <= '0;
            data_q    <= '0;
            frame_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            pending_q <= pending_d;
            ch_q      <= ch_d;
            tmo_q     <= tmo_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    // Strobes are gated by rstn so a reset cycle never emits a write or kick.
    assign sif.we           = rstn && we_c;
    assign sif.send_start   = rstn && (state_q == S_KICK);
    assign sif.fifo_data_in = data_q;
    assign busy             = state_q != S_IDLE;
    assign frame_cnt        = frame_q;
    assign err_timeout      = err_q;
endmodule

// File: tb/tb_led_frame_sched.sv
// tb/tb_led_frame_sched.sv - table-driven and sequence checks for led_frame_sched
module tb_led_frame_sched;
    logic        clk = 1'b0;
    logic        rstn, en, start;
    logic [3:0]  mr [8];
    logic [3:0]  mg [8];
    logic [3:0]  mb [8];
    logic        busy, err_timeout;
    logic [15:0] frame_cnt;
    logic        done_tbl = 1'b0;
    logic        done_auto = 1'b0;
    logic        auto_en = 1'b0;
    int          resp_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    led_frame_sched_if ifc ();
    assign ifc.send_done = done_tbl | done_auto;

    led_frame_sched #(.NCH(8), .REFRESH_CYCLES(3000), .TIMEOUT_CYCLES(100)) dut (
        .clk_slow(clk), .rstn(rstn), .en(en), .start(start),
        .MeanR(mr), .MeanG(mg), .MeanB(mb), .sif(ifc.master),
        .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Sender model: returns send_done 20 cycles after each send_start.
    always @(negedge clk) begin
        if (done_auto) done_auto = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) done_auto = 1'b1;
        end
        if (auto_en && ifc.send_start) resp_cnt = 20;
    end

    typedef struct {
        logic        start, full, done, we, chkd;
        logic [11:0] data;
        logic        ss, busy;
        logic [15:0] fc;
    } vec_t;
    vec_t tbl[$];

    logic [11:0] exp_w [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic f, input logic d, input logic w, input logic c,
                       input logic [11:0] dt, input logic ss, input logic b, input logic [15:0] fc);
        vec_t v;
        v.start = s; v.full = f; v.done = d; v.we = w; v.chkd = c;
        v.data = dt; v.ss = ss; v.busy = b; v.fc = fc;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_ss(input int maxc, input string nm);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step();
            if (ifc.send_start) seen = 1;
        end
        chk(nm, 32'(seen), 1);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        bit idle = 0;
        for (int i = 0; i < maxc && !idle; i++) begin
            step();
            if (!busy) idle = 1;
        end
        chk(nm, 32'(idle), 1);
    endtask

    int rise [3];
    logic [15:0] fc_rise [3];
    int nrise, nss, nwe;
    logic prev_busy;
    logic [11:0] got [$];

    initial begin
        exp_w = '{12'h1F7, 12'h2E8, 12'h3D9, 12'h4CA, 12'h5BB, 12'h6AC, 12'h79D, 12'h88E};
        for (int i = 0; i < 8; i++) begin
            mr[i] = 4'(i + 1); mg[i] = 4'(15 - i); mb[i] = 4'(7 + i);
        end
        rstn = 1'b0; en = 1'b0; start = 1'b0; ifc.fifo_full = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst we", 32'(ifc.we), 0);
        chk("rst send_start", 32'(ifc.send_start), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst frame_cnt", 32'(frame_cnt), 0);
        chk("rst err", 32'(err_timeout), 0);
        chk("rst data", 32'(ifc.fifo_data_in), 0);
        @(negedge clk); rstn = 1'b1;

        // Frame 1: no backpressure
        add(1, 0, 0, 0, 0, 12'h0, 0, 0, 16'd0);
        add(0, 0, 0, 0, 0, 12'h0, 0, 1, 16'd0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 1, exp_w[i], 0, 1, 16'd0);
        add(0, 0, 0, 0, 0, 12'h0, 1, 1, 16'd0);
        add(0, 0, 1, 0, 0, 12'h0, 0, 1, 16'd0);
        add(0, 0, 0, 0, 0, 12'h0, 0, 1, 16'd0);
        add(0, 0, 0, 0, 0, 12'h0, 0, 0, 16'd1);
        // Frame 2: fifo_full for 5 cycles after the 3rd write
        add(1, 0, 0, 0, 0, 12'h0, 0, 0, 16'd1);
        add(0, 0, 0, 0, 0, 12'h0, 0, 1, 16'd1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, exp_w[i], 0, 1, 16'd1);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 1, exp_w[3], 0, 1, 16'd1);
        for (int i = 3; i < 8; i++) add(0, 0, 0, 1, 1, exp_w[i], 0, 1, 16'd1);
        add(0, 0, 0, 0, 0, 12'h0, 1, 1, 16'd1);
        add(0, 0, 1, 0, 0, 12'h0, 0, 1, 16'd1);
        add(0, 0, 0, 0, 0, 12'h0, 0, 1, 16'd1);
        add(0, 0, 0, 0, 0, 12'h0, 0, 0, 16'd2);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            start = tbl[k].start; ifc.fifo_full = tbl[k].full; done_tbl = tbl[k].done;
            #1;
            chk($sformatf("row%0d we", k), 32'(ifc.we), 32'(tbl[k].we));
            chk($sformatf("row%0d send_start", k), 32'(ifc.send_start), 32'(tbl[k].ss));
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].busy));
            chk($sformatf("row%0d frame_cnt", k), 32'(frame_cnt), 32'(tbl[k].fc));
            if (tbl[k].chkd)
                chk($sformatf("row%0d data", k), 32'(ifc.fifo_data_in), 32'(tbl[k].data));
        end
        @(negedge clk); start = 1'b0; ifc.fifo_full = 1'b0; done_tbl = 1'b0;

        // Auto-refresh pacing; en dropped during the third frame
        auto_en = 1'b1;
        en = 1'b1;
        prev_busy = 1'b0; nrise = 0;
        #1;
        for (int c = 0; c < 9100 && nrise < 3; c++) begin
            if (c > 0) step();
            if (busy && !prev_busy) begin
                rise[nrise] = c; fc_rise[nrise] = frame_cnt; nrise++;
            end
            prev_busy = busy;
        end
        en = 1'b0;
        chk("refresh frames seen", 32'(nrise), 3);
        chk("refresh first latch", 32'(rise[0]), 3000);
        chk("refresh gap 1", 32'(rise[1] - rise[0]), 3000);
        chk("refresh gap 2", 32'(rise[2] - rise[1]), 3000);
        chk("refresh fc 0", 32'(fc_rise[0]), 2);
        chk("refresh fc 1", 32'(fc_rise[1]), 3);
        chk("refresh fc 2", 32'(fc_rise[2]), 4);
        wait_idle(200, "en drop idle");
        chk("en drop frame completes", 32'(frame_cnt), 5);

        // Two starts during WAIT queue exactly one extra frame
        pulse_start();
        wait_ss(50, "queue kick seen");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nss = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (ifc.send_start) nss++;
        end
        chk("queue extra kicks", 32'(nss), 1);
        chk("queue frame_cnt", 32'(frame_cnt), 7);
        chk("queue idle", 32'(busy), 0);

        // Done timeout
        auto_en = 1'b0;
        pulse_start();
        wait_ss(50, "tmo kick seen");
        for (int i = 1; i <= 100; i++) step();
        chk("tmo err before", 32'(err_timeout), 0);
        chk("tmo busy before", 32'(busy), 1);
        step();
        chk("tmo err set", 32'(err_timeout), 1);
        chk("tmo idle", 32'(busy), 0);
        chk("tmo frame_cnt", 32'(frame_cnt), 7);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tmo err cleared", 32'(err_timeout), 0);
        chk("tmo restart busy", 32'(busy), 1);
        auto_en = 1'b1;
        wait_idle(100, "tmo restart idle");
        chk("tmo restart frame_cnt", 32'(frame_cnt), 8);

        // Reset mid-WRITE after the 4th word
        pulse_start();
        nwe = 0;
        for (int i = 0; i < 20 && nwe < 4; i++) begin
            step();
            if (ifc.we) nwe++;
        end
        chk("rstmid writes before", 32'(nwe), 4);
        @(negedge clk); rstn = 1'b0; #1;
        chk("rstmid we in reset", 32'(ifc.we), 0);
        chk("rstmid ss in reset", 32'(ifc.send_start), 0);
        @(negedge clk); rstn = 1'b1; #1;
        chk("rstmid busy", 32'(busy), 0);
        chk("rstmid we", 32'(ifc.we), 0);
        chk("rstmid frame_cnt", 32'(frame_cnt), 0);
        chk("rstmid data", 32'(ifc.fifo_data_in), 0);
        pulse_start();
        nss = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ifc.we) got.push_back(ifc.fifo_data_in);
            if (ifc.send_start) nss++;
        end
        chk("rstmid new writes", 32'(got.size()), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("rstmid word%0d", i), 32'(got[i]), 32'(exp_w[i]));
        chk("rstmid new kick", 32'(nss), 1);
        chk("rstmid new frame_cnt", 32'(frame_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
